// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the multi-cycle MIPS-subset CPU. The datapath shares a
// single memory port and a single ALU, so every instruction is walked through
// fetch / decode / execute / memory / writeback, one step per clock. All
// datapath strobes and mux selects are decoded combinationally from the
// current state, the latched instruction and the memory ready handshake.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset (forces every output low)
//   instruction    IR contents, valid from DECODE onward
//   mem_ready      memory completes the current access this cycle
//   mem_read       memory read request
//   mem_write      memory write request
//   iord           memory address select: 0 = PC, 1 = ALUOut
//   ir_write       load IR from memory data
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by the zero flag
//   branch_ne      invert the zero qualification (BNE)
//   pc_src         next-PC select: 00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   alu_src_a      ALU A: 0 = PC, 1 = rs
//   alu_src_b      ALU B: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALUOp          00 add, 01 sub, 10 R-type funct, 11 I-type opcode
//   reg_dst        write register: 00 rt, 01 rd, 10 $31
//   mem_to_reg     write data: 00 ALUOut, 01 MDR, 10 PC
//   reg_write      register file write enable
//   instr_done     one-cycle pulse on the final cycle of each instruction
//   illegal_op     one-cycle pulse in DECODE for an undecodable opcode
//   state          current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        branch_ne,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ALUOp,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state
);

  localparam logic [5:0]  OP_R     = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [5:0]  FUNCT_JR = 6'b001000;
  localparam logic [31:0] INSN_NOP = 32'h0000_0000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] opcode_s;
  logic [5:0] funct_s;

  assign opcode_s = instruction[31:26];
  assign funct_s  = instruction[5:0];
  assign state    = state_r;

  // State register: the only storage in the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; rst gates every strobe so an aborted
  // instruction cannot leave a write or PC update pending.
  always_comb begin
    next_state_s  = state_r;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALUOp         = 2'b00;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    if (rst) begin
      next_state_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          // PC + 4 is computed in the ALU while the instruction is read.
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            next_state_s = S_DECODE;
          end else begin
            next_state_s = S_FETCH;
          end
        end

        S_DECODE: begin
          // Speculatively form the branch target into ALUOut.
          alu_src_b = 2'b11;
          if (instruction == INSN_NOP) begin
            instr_done   = 1'b1;
            next_state_s = S_FETCH;
          end else if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
            next_state_s = S_MEM_ADDR;
          end else if ((opcode_s == OP_R) && (funct_s == FUNCT_JR)) begin
            next_state_s = S_JR;
          end else if (opcode_s == OP_R) begin
            next_state_s = S_R_EXEC;
          end else if (opcode_s[5:3] == 3'b001) begin
            next_state_s = S_I_EXEC;
          end else if ((opcode_s == OP_BEQ) || (opcode_s == OP_BNE)) begin
            next_state_s = S_BRANCH;
          end else if (opcode_s == OP_J) begin
            next_state_s = S_JUMP;
          end else if (opcode_s == OP_JAL) begin
            next_state_s = S_JAL;
          end else begin
            illegal_op   = 1'b1;
            instr_done   = 1'b1;
            next_state_s = S_FETCH;
          end
        end

        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode_s == OP_SW) begin
            next_state_s = S_MEM_WR;
          end else begin
            next_state_s = S_MEM_RD;
          end
        end

        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            next_state_s = S_MEM_WB;
          end else begin
            next_state_s = S_MEM_RD;
          end
        end

        S_MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 2'b01;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end

        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            instr_done   = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_MEM_WR;
          end
        end

        S_R_EXEC: begin
          alu_src_a    = 1'b1;
          ALUOp        = 2'b10;
          next_state_s = S_R_WB;
        end

        S_R_WB: begin
          reg_write    = 1'b1;
          reg_dst      = 2'b01;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end

        S_I_EXEC: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          ALUOp        = 2'b11;
          next_state_s = S_I_WB;
        end

        S_I_WB: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end

        S_BRANCH: begin
          // rs - rt sets the zero flag; the target was saved in DECODE.
          alu_src_a     = 1'b1;
          ALUOp         = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          branch_ne     = (opcode_s == OP_BNE) ? 1'b1 : 1'b0;
          instr_done    = 1'b1;
          next_state_s  = S_FETCH;
        end

        S_JUMP: begin
          pc_write     = 1'b1;
          pc_src       = 2'b10;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end

        S_JAL: begin
          // PC already holds the return address (PC + 4) from FETCH.
          pc_write     = 1'b1;
          pc_src       = 2'b10;
          reg_write    = 1'b1;
          reg_dst      = 2'b10;
          mem_to_reg   = 2'b10;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end

        S_JR: begin
          pc_write     = 1'b1;
          pc_src       = 2'b11;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end

        default: begin
          // Unused encodings recover to FETCH with all strobes low.
          next_state_s = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the MIPS-subset CPU. It sequences the shared datapath (single memory port, single ALU, PC, IR, register file) through fetch, decode, execute, memory and writeback, one step per clock. It drives every datapath strobe and mux select from the current state plus the latched instruction. It waits on a memory ready handshake for every memory access.

## Interface
- No parameters. Opcode and funct values are fixed by the CPU macro set:
  - R = 6'b000000, LW = 6'b100011, SW = 6'b101011
  - BEQ = 6'b000100, BNE = 6'b000101
  - J = 6'b000010, JAL = 6'b000011
  - I-ALU: any opcode with opcode[5:3] = 3'b001
  - JR funct = 6'b001000, NOP = 32'h0000_0000
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instruction  in  32  IR contents; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by the zero flag
- branch_ne  out  1  invert the zero qualification (BNE)
- pc_src  out  2  next-PC select: 00 ALU, 01 ALUOut, 10 jump target, 11 rs
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 R-type funct, 11 I-type opcode
- reg_dst  out  2  write register: 00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an undecodable opcode
- state  out  4  current state encoding (debug)

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5
  - R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9
  - BRANCH 10, JUMP 11, JAL 12, JR 13
  - Codes 14 and 15 are unused and return to FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00.
  - Stay while mem_ready=0.
  - When mem_ready=1, also assert ir_write=1 and pc_write=1 with pc_src=00, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ALUOp=00 (branch target into ALUOut). Next state:
  - instruction==NOP → FETCH, with instr_done=1.
  - LW or SW → MEM_ADDR.
  - R with funct==JR → JR.
  - Any other R → R_EXEC.
  - I-ALU → I_EXEC.
  - BEQ or BNE → BRANCH.
  - J → JUMP.
  - JAL → JAL.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=00. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next state FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1; on that cycle assert instr_done=1 and go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUOp=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next state FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, ALUOp=11. Next state I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, pc_write_cond=1, pc_src=01, branch_ne=(opcode==BNE), instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Next state FETCH.
- JAL: same as JUMP, plus reg_write=1, reg_dst=10, mem_to_reg=10. Next state FETCH.
- JR: pc_write=1, pc_src=11, instr_done=1. Next state FETCH.
- Every output not listed for a state is 0.

## Timing
- Outputs are combinational from the state register, instruction and mem_ready (Moore plus mem_ready qualification). The state register is the only storage.
- While rst=1: state=FETCH and all outputs are forced to 0, including mem_read. state reads 0.
- After rst deasserts, FETCH begins on the first rising edge.
- Asserting rst mid-instruction aborts it immediately. Any in-flight mem_write or reg_write drops in the same cycle, and no partial PC or register update occurs after reset.
- Cycle counts with zero wait states (mem_ready tied high):
  - NOP: 2
  - J, JAL, JR, BEQ, BNE: 3
  - R-type, I-ALU, SW: 4
  - LW: 5
- Each cycle that mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read or mem_write stays asserted and stable until the mem_ready cycle inclusive.
- mem_ready is ignored in all other states.
- instr_done fires exactly once per instruction, on the cycle before the next FETCH.

## Test plan
- Reset with rst=1 mid-MEM_WR → mem_write=0 that same cycle. After release, state=0 and mem_read=1 on the next cycle.
- Fetch with mem_ready low for 3 cycles then high → mem_read high for 4 cycles. ir_write and pc_write pulse only on the 4th cycle.
- instruction=32'h8C02_0004 (LW) with mem_ready=1 → state sequence 0,1,2,3,4. In state 4: reg_write=1, mem_to_reg=01. instr_done pulses once.
- instruction=32'h1443_0002 (BNE) → in BRANCH: pc_write_cond=1, branch_ne=1, ALUOp=01. Back to state 0 after 3 cycles.
- instruction=32'h0C00_0010 (JAL) → in JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- instruction=32'h03E0_0008 (JR) → state 13 with reg_write=0. instruction=32'h0000_0000 (NOP) → back to FETCH after DECODE with no reg_write. Opcode 6'b111111 → illegal_op pulses once in DECODE.
